rssb_seq: RTL
=============

// Module: rssb_seq
// PURPOSE
//  Instruction sequencer for the RSSB (reverse-subtract, skip-if-borrow) machine;
//  the initiator that drives the memory bus (write/address/in, reads out).
//  Each instruction is one operand address A: ACC <= M[A]-ACC; M[A] <= result;
//  PC += 2 on borrow, else PC += 1. It sits between the top level and the data
//  memory (combinational read, write on clk rising edge).
// PARAMETERS
//  WIDTH     8      data/address width; PC, ACC, bus all WIDTH bits
//  RESET_PC  8'h00  PC value after reset and after restart from HALT
//  HALT_ADDR 8'h7F  fetched operand equal to this stops the machine (no write)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      level; sampled in IDLE/HALT to begin a run
//  mem_write  out  1      memory write enable, valid in EXEC only
//  mem_addr   out  WIDTH  memory address
//  mem_wdata  out  WIDTH  write data (= M[A]-ACC)
//  mem_rdata  in   WIDTH  memory read data, combinational from mem_addr
//  pc         out  WIDTH  program counter
//  acc        out  WIDTH  accumulator
//  busy       out  1      1 in FETCH/EXEC
//  halted     out  1      1 in HALT
// BEHAVIOUR
//  - States: IDLE, FETCH, EXEC, HALT. rst -> IDLE, pc=RESET_PC, acc=0, opnd=0;
//    outputs mem_write=0, busy=0, halted=0 immediately (decoded from state,
//    asynchronous with rst).
//  - IDLE: mem_addr=pc, mem_write=0. start=1 -> FETCH next edge.
//  - FETCH: mem_addr=pc, mem_write=0. At edge: opnd<=mem_rdata;
//    mem_rdata==HALT_ADDR -> HALT (pc, acc unchanged), else -> EXEC.
//  - EXEC: mem_addr=opnd; diff[WIDTH:0] = {1'b0,mem_rdata} - {1'b0,acc};
//    borrow=diff[WIDTH] (set iff mem_rdata < acc, unsigned).
//    mem_wdata=diff[WIDTH-1:0], mem_write=1 this cycle only.
//    At edge: acc<=diff[WIDTH-1:0]; pc<=pc+(borrow?2:1) mod 2^WIDTH; -> FETCH.
//  - Latency: 2 cycles per instruction (FETCH+EXEC), exactly one write each.
//  - Operand equal to pc's own word is legal: write lands at EXEC edge, next
//    FETCH reads new value.
//  - HALT: mem_write=0, mem_addr=pc. start=1 -> pc<=RESET_PC, acc<=0, -> FETCH.
//  - start ignored in FETCH/EXEC; start held high in HALT restarts every time.
//  - PC wrap: 8'hFF+1=8'h00, 8'hFF+2=8'h01, 8'hFE+2=8'h00.
//  - Reset mid-EXEC: mem_write deasserts at once; no write at following edge.
//  - mem_wdata is don't-care outside EXEC but driven (no X) after reset.
// TESTING (bench: 2^WIDTH x WIDTH behavioural memory, comb read, sync write)
//  1 Reset: assert rst -> pc=00, acc=00, mem_write=0, busy=0, halted=0 within
//    the same cycle, before any clk edge.
//  2 No borrow: M[00]=80, M[80]=05, acc=00, start -> FETCH addr 00, EXEC addr 80
//    with mem_write=1, wdata=05; after: acc=05, pc=01, M[80]=05.
//  3 Borrow: then M[01]=81, M[81]=02 -> wdata=FD, acc=FD, pc=03, M[81]=FD.
//  4 Halt: M[03]=7F -> halted=1 after FETCH, pc=03, acc=FD, no write; start ->
//    pc=00, acc=00, busy=1 next cycle.
//  5 Wrap: RESET_PC=FF, M[FF]=80, M[80]=00, acc=00 -> no borrow, pc=00;
//    repeat with M[80]=00, acc=01 -> borrow, pc from FF to 01.
//  6 Reset in EXEC: assert rst while mem_write=1 -> mem_write=0 immediately,
//    target word unchanged, state IDLE, pc=RESET_PC.

Source files
------------

// File: rtl/rssb_seq.sv
// rssb_seq: instruction sequencer for the reverse-subtract, skip-if-borrow machine
module rssb_seq #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] HALT_ADDR = WIDTH'('h7F)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             halted
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
  state_t state, next;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0] diff;
  assign diff = {1'b0, mem_rdata} - {1'b0, acc};
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  // next state and bus outputs, all decoded from the current state so reset clears them at once
  always_comb begin
    next = state;
    mem_write = 1'b0;
    mem_addr = pc;
    mem_wdata = diff[WIDTH-1:0];
    busy = 1'b0;
    halted = 1'b0;
    next = state == IDLE  ? (start ? FETCH : IDLE) :
           state == FETCH ? (mem_rdata == HALT_ADDR ? HALT : EXEC) :
           state == EXEC  ? FETCH :
                            (start ? FETCH : HALT);
    mem_write = state == EXEC;
    mem_addr = state == EXEC ? opnd : pc;
    busy = state == FETCH || state == EXEC;
    halted = state == HALT;
  end
  // datapath: latch operand, retire the subtract, skip on borrow, restart from halt
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= RESET_PC;
      acc <= '0;
      opnd <= '0;
    end else if (state == FETCH) opnd <= mem_rdata;
    else if (state == EXEC) begin
      acc <= diff[WIDTH-1:0];
      pc <= pc + (diff[WIDTH] ? WIDTH'(2) : WIDTH'(1));
    end else if (state == HALT && start) begin
      pc <= RESET_PC;
      acc <= '0;
    end
endmodule
